// File: rtl/bf_pkg.sv
// Shared definitions for the brainfuck_uP boot loader: bus widths, the
// loader state encoding and small state-classification helpers.
package bf_pkg;

  localparam int BF_ADDR_W = 16;
  localparam int BF_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    HDR_LO = 3'd2,
    HDR_HI = 3'd3,
    LOAD   = 3'd4,
    CHK    = 3'd5,
    RUN    = 3'd6,
    ERR    = 3'd7
  } state_t;

  // States in which the loader presents rx_ready to the host.
  function automatic logic is_rx_state(input state_t s);
    case (s)
      HDR_LO, HDR_HI, LOAD, CHK: is_rx_state = 1'b1;
      default:                   is_rx_state = 1'b0;
    endcase
  endfunction

  // States that count as an in-progress boot sequence.
  function automatic logic is_busy_state(input state_t s);
    case (s)
      CLEAR, HDR_LO, HDR_HI, LOAD, CHK: is_busy_state = 1'b1;
      default:                          is_busy_state = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/bf_loader_ctrl.sv
// Boot sequencer for brainfuck_uP: holds the CPU in reset, zeroes the data
// RAM, loads a length-prefixed program into the instruction ROM and then
// releases the CPU.
// Optional feature macro: BF_LOADER_CHECKSUM_EN (adds a trailing mod-256
// checksum byte after the program, checked in the CHK state).
// All outputs are driven straight from flops.
module bf_loader_ctrl
  import bf_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 30000,
  parameter int unsigned ROM_WORDS = 65536
) (
  input  logic                 bfup_clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BF_DATA_W-1:0] rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  output logic [BF_ADDR_W-1:0] ram_addr,
  output logic [BF_DATA_W-1:0] ram_wdata,
  output logic                 ram_we_n,
  output logic [BF_ADDR_W-1:0] rom_addr,
  output logic [BF_DATA_W-1:0] rom_wdata,
  output logic                 rom_we_n,
  output logic                 cpu_reset_n,
  output logic                 busy,
  output logic                 done,
  output logic                 err
);

  // Last RAM address written during CLEAR, and the largest legal length.
  localparam logic [BF_ADDR_W-1:0] RAM_LAST = BF_ADDR_W'(RAM_WORDS - 1);
  localparam logic [16:0]          ROM_MAX  = 17'(ROM_WORDS);

  state_t state_r, state_s;

  // 17-bit length and byte counter so that a 65536-byte program fits.
  logic [16:0] len_r, len_s;
  logic [16:0] cnt_r, cnt_s;
  logic [16:0] hdr_len_s;
  logic        xfer_s;
  logic        run_s;

  logic                 rx_ready_r, rx_ready_s;
  logic [BF_ADDR_W-1:0] ram_addr_r, ram_addr_s;
  logic                 ram_we_n_r, ram_we_n_s;
  logic [BF_ADDR_W-1:0] rom_addr_r, rom_addr_s;
  logic [BF_DATA_W-1:0] rom_wdata_r, rom_wdata_s;
  logic                 rom_we_n_r, rom_we_n_s;
  logic                 cpu_reset_n_r, cpu_reset_n_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;
  logic                 err_r, err_s;

`ifdef BF_LOADER_CHECKSUM_EN
  logic [BF_DATA_W-1:0] sum_r, sum_s;
`endif

  // rx_ready_r always mirrors the current state, so this is the handshake.
  assign xfer_s    = rx_valid && rx_ready_r;
  assign hdr_len_s = {1'b0, rx_data, len_r[7:0]};

  // Next-state, datapath and next-output decode.
  always_comb begin
    state_s     = state_r;
    len_s       = len_r;
    cnt_s       = cnt_r;
    ram_addr_s  = ram_addr_r;
    ram_we_n_s  = 1'b1;
    rom_addr_s  = rom_addr_r;
    rom_wdata_s = rom_wdata_r;
    rom_we_n_s  = 1'b1;
`ifdef BF_LOADER_CHECKSUM_EN
    sum_s       = sum_r;
`endif

    case (state_r)
      IDLE, RUN, ERR: begin
        if (start) begin
          // First CLEAR write (address 0) is issued on the same edge.
          state_s    = CLEAR;
          ram_addr_s = {BF_ADDR_W{1'b0}};
          ram_we_n_s = 1'b0;
        end else begin
          state_s = state_r;
        end
      end

      CLEAR: begin
        if (ram_addr_r == RAM_LAST) begin
          state_s = HDR_LO;
`ifdef BF_LOADER_CHECKSUM_EN
          sum_s   = {BF_DATA_W{1'b0}};
`endif
        end else begin
          ram_addr_s = ram_addr_r + 16'd1;
          ram_we_n_s = 1'b0;
        end
      end

      HDR_LO: begin
        if (xfer_s) begin
          len_s   = {9'd0, rx_data};
          state_s = HDR_HI;
        end else begin
          state_s = HDR_LO;
        end
      end

      HDR_HI: begin
        if (xfer_s) begin
          len_s = hdr_len_s;
          cnt_s = 17'd0;
          if ((hdr_len_s == 17'd0) || (hdr_len_s > ROM_MAX)) begin
            state_s = ERR;
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = HDR_HI;
        end
      end

      LOAD: begin
        if (xfer_s) begin
          rom_we_n_s  = 1'b0;
          rom_addr_s  = cnt_r[BF_ADDR_W-1:0];
          rom_wdata_s = rx_data;
          cnt_s       = cnt_r + 17'd1;
`ifdef BF_LOADER_CHECKSUM_EN
          sum_s       = sum_r + rx_data;
`endif
          if ((cnt_r + 17'd1) == len_r) begin
`ifdef BF_LOADER_CHECKSUM_EN
            state_s = CHK;
`else
            state_s = RUN;
`endif
          end else begin
            state_s = LOAD;
          end
        end else begin
          state_s = LOAD;
        end
      end

`ifdef BF_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer_s) begin
          if (rx_data == sum_r) begin
            state_s = RUN;
          end else begin
            state_s = ERR;
          end
        end else begin
          state_s = CHK;
        end
      end
`endif

      default: begin
        state_s = IDLE;
      end
    endcase

    // The CPU leaves reset only from the second RUN cycle onward, so the
    // last ROM write cycle has finished first. Leaving RUN drops it on
    // the same edge. busy stays high until done takes over.
    run_s         = (state_s == RUN) && (state_r == RUN);
    rx_ready_s    = is_rx_state(state_s);
    busy_s        = is_busy_state(state_s) || ((state_s == RUN) && (state_r != RUN));
    done_s        = run_s;
    cpu_reset_n_s = run_s;
    err_s         = (state_s == ERR);
  end

  // State register.
  always_ff @(posedge bfup_clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Counters, captured length and registered outputs.
  always_ff @(posedge bfup_clk or negedge reset) begin
    if (!reset) begin
      len_r         <= 17'd0;
      cnt_r         <= 17'd0;
      rx_ready_r    <= 1'b0;
      ram_addr_r    <= {BF_ADDR_W{1'b0}};
      ram_we_n_r    <= 1'b1;
      rom_addr_r    <= {BF_ADDR_W{1'b0}};
      rom_wdata_r   <= {BF_DATA_W{1'b0}};
      rom_we_n_r    <= 1'b1;
      cpu_reset_n_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      len_r         <= len_s;
      cnt_r         <= cnt_s;
      rx_ready_r    <= rx_ready_s;
      ram_addr_r    <= ram_addr_s;
      ram_we_n_r    <= ram_we_n_s;
      rom_addr_r    <= rom_addr_s;
      rom_wdata_r   <= rom_wdata_s;
      rom_we_n_r    <= rom_we_n_s;
      cpu_reset_n_r <= cpu_reset_n_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      err_r         <= err_s;
    end
  end

`ifdef BF_LOADER_CHECKSUM_EN
  // Running mod-256 sum of program bytes.
  always_ff @(posedge bfup_clk or negedge reset) begin
    if (!reset) begin
      sum_r <= {BF_DATA_W{1'b0}};
    end else begin
      sum_r <= sum_s;
    end
  end
`endif

  assign rx_ready    = rx_ready_r;
  assign ram_addr    = ram_addr_r;
  assign ram_wdata   = {BF_DATA_W{1'b0}};
  assign ram_we_n    = ram_we_n_r;
  assign rom_addr    = rom_addr_r;
  assign rom_wdata   = rom_wdata_r;
  assign rom_we_n    = rom_we_n_r;
  assign cpu_reset_n = cpu_reset_n_r;
  assign busy        = busy_r;
  assign done        = done_r;
  assign err         = err_r;

endmodule

// File: tb/tb_bf_loader_ctrl.sv
// Self-checking bench for bf_loader_ctrl with RAM_WORDS=8, ROM_WORDS=256.
// Covers both builds; the checksum sequences are enabled by
// BF_LOADER_CHECKSUM_EN.
module tb_bf_loader_ctrl;

  logic        bfup_clk;
  logic        reset;
  logic        start;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we_n;
  logic [15:0] rom_addr;
  logic [7:0]  rom_wdata;
  logic        rom_we_n;
  logic        cpu_reset_n;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  logic [15:0] log_addr[$];
  logic [7:0]  log_data[$];

  // Output vector: rx_ready, ram_we_n, ram_addr, rom_we_n, rom_addr, rom_wdata,
  // cpu_reset_n, busy, done, err.
  typedef struct packed {
    logic        start;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [46:0] exp;
  } vec_t;

  vec_t tbl[24];
  int   n_vec = 0;

  localparam logic [46:0] RST_VEC = {1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 8'h00,
                                     1'b0, 1'b0, 1'b0, 1'b0};

  bf_loader_ctrl #(.RAM_WORDS(8), .ROM_WORDS(256)) dut (
    .bfup_clk(bfup_clk), .reset(reset), .start(start),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we_n(ram_we_n),
    .rom_addr(rom_addr), .rom_wdata(rom_wdata), .rom_we_n(rom_we_n),
    .cpu_reset_n(cpu_reset_n), .busy(busy), .done(done), .err(err)
  );

  initial bfup_clk = 1'b0;
  always #5 bfup_clk = ~bfup_clk;

  // ROM write monitor, sampled mid-cycle.
  always @(negedge bfup_clk) begin
    if (reset && !rom_we_n) begin
      log_addr.push_back(rom_addr);
      log_data.push_back(rom_wdata);
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic logic [46:0] outs();
    return {rx_ready, ram_we_n, ram_addr, rom_we_n, rom_addr, rom_wdata,
            cpu_reset_n, busy, done, err};
  endfunction

  function automatic vec_t mk(input logic st, input logic v, input logic [7:0] d,
                              input logic rr, input logic rwe, input logic [15:0] ra,
                              input logic owe, input logic [15:0] oa, input logic [7:0] od,
                              input logic crn, input logic b, input logic dn, input logic er);
    vec_t r;
    r.start    = st;
    r.rx_valid = v;
    r.rx_data  = d;
    r.exp      = {rr, rwe, ra, owe, oa, od, crn, b, dn, er};
    return r;
  endfunction

  task automatic add(input vec_t v);
    tbl[n_vec] = v;
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte; with rnd set, rx_valid is randomised each cycle.
  task automatic send_byte(input logic [7:0] b, input bit rnd);
    int  guard;
    bit  sent;
    guard = 0;
    sent  = 1'b0;
    rx_data = b;
    while (!sent && guard < 200) begin
      rx_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      sent     = rx_valid && rx_ready;
      @(posedge bfup_clk); #1;
      guard++;
    end
    rx_valid = 1'b0;
    if (!sent) begin
      n_checks++;
      n_errors++;
      $display("FAIL send_byte: byte %0h not accepted within 200 cycles", b);
    end
  endtask

  // Pulse start, check the first CLEAR cycle and the CLEAR length.
  task automatic do_start_clear(input string name);
    int cyc;
    start = 1'b1;
    @(posedge bfup_clk); #1;
    start = 1'b0;
    chk({name, "_entry"}, {busy, cpu_reset_n, done, err, ram_we_n, ram_addr},
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    cyc = 0;
    while (!rx_ready && cyc < 50) begin
      @(posedge bfup_clk); #1;
      cyc++;
    end
    chk({name, "_clear_len"}, cyc, 8);
  endtask

  initial begin
    int bad;
    reset = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    repeat (3) @(posedge bfup_clk);
    #1;
    chk("reset_vals", outs(), RST_VEC);
    chk("ram_wdata_zero", ram_wdata, 8'h00);

    // Idle for 100 cycles: no strobes, CPU held in reset.
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge bfup_clk); #1;
      if (!ram_we_n || !rom_we_n || cpu_reset_n || busy || rx_ready) bad++;
    end
    chk("idle_100", bad, 0);

    // Table: start, 8-word CLEAR, then 03 00 2B 2E 5B with rx_valid held.
    add(mk(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 16'd0, 1'b1, 16'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    for (int k = 1; k < 8; k++)
      add(mk(k == 4, 1'b0, 8'h00, 1'b0, 1'b0, 16'(k), 1'b1, 16'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    add(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'd7, 1'b1, 16'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    add(mk(1'b0, 1'b1, 8'h03, 1'b1, 1'b1, 16'd7, 1'b1, 16'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    add(mk(1'b0, 1'b1, 8'h00, 1'b1, 1'b1, 16'd7, 1'b1, 16'd0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0));
    add(mk(1'b0, 1'b1, 8'h2B, 1'b1, 1'b1, 16'd7, 1'b0, 16'd0, 8'h2B, 1'b0, 1'b1, 1'b0, 1'b0));
    add(mk(1'b1, 1'b1, 8'h2E, 1'b1, 1'b1, 16'd7, 1'b0, 16'd1, 8'h2E, 1'b0, 1'b1, 1'b0, 1'b0));
`ifdef BF_LOADER_CHECKSUM_EN
    add(mk(1'b0, 1'b1, 8'h5B, 1'b1, 1'b1, 16'd7, 1'b0, 16'd2, 8'h5B, 1'b0, 1'b1, 1'b0, 1'b0));
    add(mk(1'b0, 1'b1, 8'hB4, 1'b0, 1'b1, 16'd7, 1'b1, 16'd2, 8'h5B, 1'b0, 1'b1, 1'b0, 1'b0));
`else
    add(mk(1'b0, 1'b1, 8'h5B, 1'b0, 1'b1, 16'd7, 1'b0, 16'd2, 8'h5B, 1'b0, 1'b1, 1'b0, 1'b0));
`endif
    add(mk(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 16'd7, 1'b1, 16'd2, 8'h5B, 1'b1, 1'b0, 1'b1, 1'b0));
    add(mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'd7, 1'b1, 16'd2, 8'h5B, 1'b1, 1'b0, 1'b1, 1'b0));

    for (int i = 0; i < n_vec; i++) begin
      start    = tbl[i].start;
      rx_valid = tbl[i].rx_valid;
      rx_data  = tbl[i].rx_data;
      @(posedge bfup_clk); #1;
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end
    start = 1'b0; rx_valid = 1'b0;

    chk("tbl_rom_count", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("tbl_rom0", {log_addr[0], log_data[0]}, {16'd0, 8'h2B});
      chk("tbl_rom1", {log_addr[1], log_data[1]}, {16'd1, 8'h2E});
      chk("tbl_rom2", {log_addr[2], log_data[2]}, {16'd2, 8'h5B});
    end

    // Zero length header.
    do_start_clear("restart_run");
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    chk("len_zero_err", {err, cpu_reset_n, rx_ready, busy, done}, 5'b10000);

    // Length 0x0101 exceeds ROM_WORDS=256; entry check also sees err cleared.
    do_start_clear("restart_err");
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    chk("len_big_err", {err, cpu_reset_n, rx_ready, busy, done}, 5'b10000);

    // Asynchronous reset after the first of three program bytes.
    do_start_clear("restart_err2");
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h11, 1'b0);
    chk("midload_write", {rom_we_n, rom_addr, rom_wdata}, {1'b0, 16'd0, 8'h11});
    reset = 1'b0;
    #1;
    chk("midload_reset", outs(), RST_VEC);
    repeat (3) @(posedge bfup_clk);
    #1;
    chk("midload_reset_hold", outs(), RST_VEC);
    reset = 1'b1;
    repeat (2) @(posedge bfup_clk);
    #1;
    chk("after_reset_idle", {busy, cpu_reset_n, rx_ready}, 3'b000);

    // Load with rx_valid toggled randomly.
    log_addr.delete();
    log_data.delete();
    do_start_clear("rand_load");
    send_byte(8'h03, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b1);
    send_byte(8'h43, 1'b1);
`ifdef BF_LOADER_CHECKSUM_EN
    send_byte(8'hC6, 1'b1);
`endif
    chk("rand_cpu_still_reset", {cpu_reset_n, done}, 2'b00);
    @(posedge bfup_clk); #1;
    chk("rand_run", {done, cpu_reset_n, busy, rx_ready, err}, 5'b11000);
    chk("rand_rom_count", log_addr.size(), 3);
    if (log_addr.size() == 3) begin
      chk("rand_rom0", {log_addr[0], log_data[0]}, {16'd0, 8'h41});
      chk("rand_rom1", {log_addr[1], log_data[1]}, {16'd1, 8'h42});
      chk("rand_rom2", {log_addr[2], log_data[2]}, {16'd2, 8'h43});
    end

`ifdef BF_LOADER_CHECKSUM_EN
    // Correct checksum 0x30 for 10 20.
    do_start_clear("cks_ok");
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h30, 1'b0);
    @(posedge bfup_clk); #1;
    chk("cks_ok_run", {done, cpu_reset_n, err}, 3'b110);

    // Wrong checksum 0x31.
    do_start_clear("cks_bad");
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h31, 1'b0);
    chk("cks_bad_err", {err, cpu_reset_n, done, rx_ready}, 4'b1000);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
